// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the PC sequencer: FSM state
//               encoding, PC increment, default reset address and the
//               redirect-target alignment helper.
// Macro       : PC_MISALIGN_TRAP_EN selects 2-byte (trap on bit 1) vs
//               4-byte target alignment.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_TRAP  = 2'd3
   } pc_state_e;

   localparam logic [31:0] PC_INC            = 32'd4;
   localparam logic [31:0] PC_RESET_ADDR_DEF = 32'h0000_0000;

   // Bits cleared from a redirect target before it is loaded into the PC.
   function automatic logic [31:0] align_target(input logic [31:0] target);
`ifdef PC_MISALIGN_TRAP_EN
      return {target[31:1], 1'b0};
`else
      return {target[31:2], 2'b00};
`endif
   endfunction

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Saturating up-counter with synchronous clear. Stops at
//               all-ones and never wraps.
// Ports       : i_clk  - clock
//               i_clr  - synchronous clear (highest priority)
//               i_inc  - increment request
//               o_cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq
// Description : Program-counter sequencer. Produces the fetch address each
//               cycle, advancing by 4, holding on stall, and redirecting on
//               request with a one-cycle flush bubble. Counts accepted
//               redirects with a saturating counter.
// Macro       : PC_MISALIGN_TRAP_EN - when defined, targets keep bit 1 and a
//               target with bit 1 set enters a sticky TRAP state instead of
//               redirecting. When undefined, targets are word-aligned and
//               o_trap is tied low.
// Ports       : i_clk, i_rst        - clock, synchronous active-high reset
//               i_jump_cntr/i_target - redirect request and target address
//               i_stall              - hold request
//               o_pc / o_pc_plus4    - fetch address and fetch address + 4
//               o_valid / o_flush    - live fetch / squash younger work
//               o_trap               - misaligned-target trap
//               o_redirect_cnt       - accepted redirects (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR_DEF,
   parameter int          CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_jump_cntr,
   input  logic [31:0]      i_target,
   input  logic             i_stall,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_pc_plus4,
   output logic             o_valid,
   output logic             o_flush,
   output logic             o_trap,
   output logic [CNT_W-1:0] o_redirect_cnt
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        flush_q, flush_d;
   // Set by reset so BOOT is held for one full cycle after reset release.
   logic        boot_wait_q, boot_wait_d;
   logic        cnt_inc;
   logic [31:0] w_target;
   logic        w_misalign;

   assign w_target = align_target(i_target);

`ifdef PC_MISALIGN_TRAP_EN
   assign w_misalign = i_target[1];
`else
   assign w_misalign = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_BOOT;
         boot_wait_q <= 1'b1;
         pc_q        <= RESET_ADDR;
         valid_q     <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_wait_q <= boot_wait_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         flush_q     <= flush_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      boot_wait_d = 1'b0;
      case (state_q)
         ST_BOOT:  if (!boot_wait_q) state_d = ST_RUN;
         ST_RUN:   if (i_jump_cntr) state_d = w_misalign ? ST_TRAP : ST_FLUSH;
         ST_FLUSH: state_d = ST_RUN;
         ST_TRAP:  state_d = ST_TRAP;
         default:  state_d = ST_BOOT;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Computes the values the registered outputs take after this edge.
   always_comb begin
      pc_d    = pc_q;
      valid_d = 1'b0;
      flush_d = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_BOOT: begin
            pc_d    = RESET_ADDR;
            valid_d = !boot_wait_q;
         end
         ST_RUN: begin
            if (i_jump_cntr) begin
               // Redirect beats stall; flush is raised for both the
               // normal redirect and the first trap cycle.
               pc_d    = w_target;
               flush_d = 1'b1;
               cnt_inc = !w_misalign;
            end else if (i_stall) begin
               valid_d = 1'b1;
            end else begin
               pc_d    = pc_q + PC_INC;
               valid_d = 1'b1;
            end
         end
         ST_FLUSH: valid_d = 1'b1;
         ST_TRAP:  valid_d = 1'b0;
         default:  valid_d = 1'b0;
      endcase
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic trap_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         trap_q <= 1'b0;
      end else if (state_q == ST_RUN && i_jump_cntr && w_misalign) begin
         trap_q <= 1'b1;
      end
   end

   assign o_trap = trap_q;
`else
   assign o_trap = 1'b0;
`endif

   sat_cnt #(
      .WIDTH (CNT_W)
   ) u_redirect_cnt (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_inc (cnt_inc),
      .o_cnt (o_redirect_cnt)
   );

   assign o_pc       = pc_q;
   assign o_pc_plus4 = pc_q + PC_INC;
   assign o_valid    = valid_q;
   assign o_flush    = flush_q;

endmodule : pc_seq
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq
// Description : Scoreboard bench for pc_seq. A behavioural model predicts the
//               outputs for each applied input vector; a monitor compares the
//               DUT against the queued predictions one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

   localparam int          CW    = 3;
   localparam logic [31:0] RST_A = 32'h0000_0000;
   localparam int          CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          jump = 1'b0;
   logic          stall = 1'b0;
   logic [31:0]   tgt = 32'h0;
   logic [31:0]   pc, pc4;
   logic          valid, flush, trap;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   pc_seq #(
      .RESET_ADDR (RST_A),
      .CNT_W      (CW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_jump_cntr    (jump),
      .i_target       (tgt),
      .i_stall        (stall),
      .o_pc           (pc),
      .o_pc_plus4     (pc4),
      .o_valid        (valid),
      .o_flush        (flush),
      .o_trap         (trap),
      .o_redirect_cnt (cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        flush;
      logic        trap;
      int          cnt;
   } exp_t;

   exp_t sb[$];
   int   vecs = 0;
   int   errs = 0;

   // Model: cycles left before fetch starts, pending flush bubble, trap flags.
   logic [31:0] m_pc = 32'h0;
   int          m_boot = 2;
   bit          m_bubble = 1'b0;
   bit          m_trapped = 1'b0;
   bit          m_trap_first = 1'b0;
   int          m_cnt = 0;

   function automatic bit m_live();
      return (m_boot == 0) && !m_bubble && !m_trapped;
   endfunction

   task automatic step(input bit r, input bit j, input logic [31:0] t, input bit s);
      logic [31:0] a;
      bit          mis;
      exp_t        e;
      @(negedge clk);
      rst = r; jump = j; tgt = t; stall = s;
`ifdef PC_MISALIGN_TRAP_EN
      a   = t & 32'hFFFF_FFFE;
      mis = t[1];
`else
      a   = t & 32'hFFFF_FFFC;
      mis = 1'b0;
`endif
      if (r) begin
         m_pc = RST_A; m_boot = 2; m_bubble = 0;
         m_trapped = 0; m_trap_first = 0; m_cnt = 0;
      end else if (m_boot > 0) begin
         m_boot--;
      end else if (m_trapped) begin
         m_trap_first = 0;
      end else if (m_bubble) begin
         m_bubble = 0;
      end else if (j) begin
         m_pc = a;
         if (mis) begin
            m_trapped = 1; m_trap_first = 1;
         end else begin
            m_bubble = 1;
            if (m_cnt < CMAX) m_cnt++;
         end
      end else if (!s) begin
         m_pc = m_pc + 32'd4;
      end
      e.pc    = m_pc;
      e.valid = m_live();
      e.flush = m_bubble || m_trap_first;
      e.trap  = m_trapped;
      e.cnt   = m_cnt;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic idle_until(input logic [31:0] addr);
      int n = 0;
      while (!(m_live() && m_pc == addr)) begin
         if (n >= 64) begin
            $display("FAIL wait_pc: pc %h not reached, required %h", m_pc, addr);
            errs++;
            break;
         end
         step(1'b0, 1'b0, 32'h0, 1'b0);
         n++;
      end
   endtask

   // Monitor: compare each presented output vector against the scoreboard.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vecs++;
         if (pc !== e.pc || pc4 !== (e.pc + 32'd4) || valid !== e.valid ||
             flush !== e.flush || trap !== e.trap || cnt !== CW'(e.cnt)) begin
            errs++;
            $display("FAIL vec%0d: got pc=%h pc4=%h v=%b f=%b t=%b cnt=%0d, required pc=%h pc4=%h v=%b f=%b t=%b cnt=%0d",
                     vecs, pc, pc4, valid, flush, trap, cnt,
                     e.pc, e.pc + 32'd4, e.valid, e.flush, e.trap, e.cnt);
         end
      end
   end

   initial begin
      // Reset and boot: fetch starts at 0x0, 0x4, 0x8.
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h44, 1'b1);
      idle(5);
      // Redirect from 0x10 with odd target.
      idle_until(32'h10);
      step(1'b0, 1'b1, 32'h101, 1'b0);
      idle(3);
      // Stall at 0x20, then stall plus redirect.
      step(1'b0, 1'b1, 32'h1C, 1'b0);
      idle_until(32'h20);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 32'h40, 1'b1);
      idle(2);
      // Wrap past the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      idle(3);
      // Redirect issued during the flush cycle is ignored.
      step(1'b0, 1'b1, 32'h200, 1'b0);
      step(1'b0, 1'b1, 32'h300, 1'b1);
      idle(2);
      // Saturate the redirect counter.
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         step(1'b0, 1'b1, 32'h1000 + 32'(i * 16), 1'b0);
         step(1'b0, 1'b0, 32'h0, 1'b0);
      end
      // Target with bit 1 set: trap or aligned redirect, then reset pulse.
      step(1'b0, 1'b1, 32'h102, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 32'h0, 1'b0);
      idle(4);
      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
              $urandom, $urandom_range(0, 3) == 0);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d predictions left, required 0", sb.size());
         errs++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_pc_seq
`default_nettype wire
